// File: rtl/register_heap_view.sv
// Paged, frame-snapshotted hex view of a CPU register bank for the VGA debug overlay.
// Define REG_HEAP_CHANGE_HILITE_EN to build per-register change highlighting (changed_hit).
module register_heap_view #(
    parameter int REG_COUNT   = 11,
    parameter int ROWS        = 4,
    parameter int DELTA_Y     = 60,
    parameter int HOLD_FRAMES = 30
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [10:0]               x,
    input  logic [10:0]               y,
    input  logic [10:0]               cx,
    input  logic [10:0]               cy,
    input  logic [REG_COUNT*16-1:0]   registers,
    input  logic                      frame_start,
    input  logic                      page_next,
    output logic [3:0]                first_index,
    output logic                      hit,
    output logic                      changed_hit
);

    // A cell is five 3x5 glyphs (index, then four value nibbles MSB first),
    // each drawn at 2x scale on an 8x10 pixel pitch, centred on the row centre.
    localparam logic signed [13:0] HALF_W = 14'sd20;
    localparam logic signed [13:0] HALF_H = 14'sd5;
    localparam logic signed [13:0] CELL_W = 14'sd40;
    localparam logic signed [13:0] CELL_H = 14'sd10;

    logic [15:0]        snap_q [REG_COUNT];
    logic [15:0]        live   [REG_COUNT];
    logic [3:0]         first_index_q, first_index_d;
    logic               pend_q, pend_d;
    logic               hit_q, changed_hit_q;
    logic               hit_c, changed_hit_c;
    logic [ROWS-1:0]    row_hit;
    logic [5:0]         page_sum;
    logic signed [13:0] dx;

`ifdef REG_HEAP_CHANGE_HILITE_EN
    localparam int HOLD_W = $clog2(HOLD_FRAMES + 1);
    logic [HOLD_W-1:0]  hold_q [REG_COUNT];
    logic               primed_q;
    logic [ROWS-1:0]    row_chg;
`endif

    function automatic logic [14:0] glyph_bits(input logic [3:0] d);
        logic [14:0] g;
        case (d)
            4'h0: g = 15'h7B6F;
            4'h1: g = 15'h2C97;
            4'h2: g = 15'h73E7;
            4'h3: g = 15'h73CF;
            4'h4: g = 15'h5BC9;
            4'h5: g = 15'h79CF;
            4'h6: g = 15'h79EF;
            4'h7: g = 15'h7249;
            4'h8: g = 15'h7BEF;
            4'h9: g = 15'h7BCF;
            4'hA: g = 15'h2BED;
            4'hB: g = 15'h6BAE;
            4'hC: g = 15'h7927;
            4'hD: g = 15'h6B6E;
            4'hE: g = 15'h79E7;
            default: g = 15'h79E4;
        endcase
        return g;
    endfunction

    // Glyph bitmaps are row-major with row 0 / column 0 in bit 14; column 3 is the inter-glyph gap.
    function automatic logic font_px(input logic [3:0] d, input logic [2:0] frow,
                                     input logic [1:0] fcol);
        logic [14:0] bits;
        logic [3:0]  pos;
        bits = glyph_bits(d);
        pos  = 4'(frow) * 4'd3 + 4'(fcol);
        if (fcol == 2'd3 || frow > 3'd4) begin
            return 1'b0;
        end
        return bits[4'd14 - pos];
    endfunction

    for (genvar k = 0; k < REG_COUNT; k++) begin : g_unpack
        assign live[k] = registers[(REG_COUNT-k)*16-1 -: 16];
    end

    assign dx = $signed({3'b000, x}) - $signed({3'b000, cx}) + HALF_W;

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        localparam logic signed [12:0] ROW_OFF =
            13'(r * DELTA_Y + DELTA_Y / 2 - (ROWS * DELTA_Y) / 2);

        logic signed [12:0] ccy;
        logic signed [13:0] dy;
        logic [4:0]         idx;
        logic [15:0]        val;
        logic [3:0]         digit;
        logic               in_box;

        assign ccy    = $signed({2'b00, cy}) + ROW_OFF;
        assign dy     = $signed({3'b000, y}) - $signed({ccy[12], ccy}) + HALF_H;
        assign idx    = 5'(first_index_q) + 5'(r);
        // Rows past the end of the bank and rows centred above the screen stay blank.
        assign in_box = (idx < 5'(REG_COUNT)) && !ccy[12] &&
                        (dx >= 14'sd0) && (dx < CELL_W) &&
                        (dy >= 14'sd0) && (dy < CELL_H);

        always_comb begin
            val = '0;
            for (int k = 0; k < REG_COUNT; k++) begin
                if (idx == 5'(k)) val = snap_q[k];
            end
        end

        always_comb begin
            case (dx[5:3])
                3'd0:    digit = idx[3:0];
                3'd1:    digit = val[15:12];
                3'd2:    digit = val[11:8];
                3'd3:    digit = val[7:4];
                default: digit = val[3:0];
            endcase
        end

        assign row_hit[r] = in_box && font_px(digit, dy[3:1], dx[2:1]);

`ifdef REG_HEAP_CHANGE_HILITE_EN
        logic chg;
        always_comb begin
            chg = 1'b0;
            for (int k = 0; k < REG_COUNT; k++) begin
                if (idx == 5'(k)) chg = row_hit[r] && (hold_q[k] != '0);
            end
        end
        assign row_chg[r] = chg;
`endif
    end

    assign hit_c = |row_hit;
`ifdef REG_HEAP_CHANGE_HILITE_EN
    assign changed_hit_c = |row_chg;
`else
    assign changed_hit_c = 1'b0;
`endif

    // Paging requests are only honoured at a frame boundary, so row 0 never shifts mid-frame.
    assign page_sum = {2'b00, first_index_q} + 6'(ROWS);

    always_comb begin
        pend_d        = pend_q | page_next;
        first_index_d = first_index_q;
        if (frame_start) begin
            pend_d = 1'b0;
            if (pend_q || page_next) begin
                first_index_d = (page_sum >= 6'(REG_COUNT)) ? 4'd0 : page_sum[3:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            first_index_q <= '0;
            pend_q        <= 1'b0;
            hit_q         <= 1'b0;
            changed_hit_q <= 1'b0;
            for (int k = 0; k < REG_COUNT; k++) snap_q[k] <= '0;
        end else begin
            first_index_q <= first_index_d;
            pend_q        <= pend_d;
            hit_q         <= hit_c;
            changed_hit_q <= changed_hit_c;
            if (frame_start) begin
                for (int k = 0; k < REG_COUNT; k++) snap_q[k] <= live[k];
            end
        end
    end

`ifdef REG_HEAP_CHANGE_HILITE_EN
    // Comparing the live bus against the previous snapshot detects a change once per frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            primed_q <= 1'b0;
            for (int k = 0; k < REG_COUNT; k++) hold_q[k] <= '0;
        end else if (frame_start) begin
            primed_q <= 1'b1;
            for (int k = 0; k < REG_COUNT; k++) begin
                if (primed_q && (live[k] != snap_q[k])) begin
                    hold_q[k] <= HOLD_W'(HOLD_FRAMES);
                end else if (hold_q[k] != '0) begin
                    hold_q[k] <= hold_q[k] - 1'b1;
                end
            end
        end
    end
`endif

    assign first_index = first_index_q;
    assign hit         = hit_q;
    assign changed_hit = changed_hit_q;

endmodule

// File: tb/tb_register_heap_view.sv
// Self-checking bench for register_heap_view against a behavioural model of the row layout,
// glyph font, paging and change-highlight rules.
module tb_register_heap_view;

    localparam int REG_COUNT   = 11;
    localparam int ROWS        = 4;
    localparam int DELTA_Y     = 60;
    localparam int HOLD_FRAMES = 3;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [10:0]             x, y, cx, cy;
    logic [REG_COUNT*16-1:0] registers;
    logic                    frame_start, page_next;
    logic [3:0]              first_index;
    logic                    hit, changed_hit;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [15:0] live_m [REG_COUNT];
    logic [15:0] m_snap [REG_COUNT];
    int          last_chg [REG_COUNT];
    int          m_first;
    bit          m_pend;
    bit          m_primed;
    int          frame_no;

    always #5 clk = ~clk;

    register_heap_view #(
        .REG_COUNT(REG_COUNT), .ROWS(ROWS), .DELTA_Y(DELTA_Y), .HOLD_FRAMES(HOLD_FRAMES)
    ) dut (
        .clk(clk), .rst(rst), .x(x), .y(y), .cx(cx), .cy(cy),
        .registers(registers), .frame_start(frame_start), .page_next(page_next),
        .first_index(first_index), .hit(hit), .changed_hit(changed_hit)
    );

    function automatic string font_of(int d);
        case (d)
            0:  return "### #.# #.# #.# ###";
            1:  return ".#. ##. .#. .#. ###";
            2:  return "### ..# ### #.. ###";
            3:  return "### ..# ### ..# ###";
            4:  return "#.# #.# ### ..# ..#";
            5:  return "### #.. ### ..# ###";
            6:  return "### #.. ### #.# ###";
            7:  return "### ..# ..# ..# ..#";
            8:  return "### #.# ### #.# ###";
            9:  return "### #.# ### ..# ###";
            10: return ".#. #.# ### #.# #.#";
            11: return "##. #.# ##. #.# ##.";
            12: return "### #.. #.. #.. ###";
            13: return "##. #.# #.# #.# ##.";
            14: return "### #.. ### #.. ###";
            default: return "### #.. ### #.. #..";
        endcase
    endfunction

    function automatic bit model_hl(int i);
        bit en;
`ifdef REG_HEAP_CHANGE_HILITE_EN
        en = 1'b1;
`else
        en = 1'b0;
`endif
        return en && ((frame_no - last_chg[i]) < HOLD_FRAMES);
    endfunction

    function automatic int row_centre_y(int r);
        return int'(cy) - (ROWS * DELTA_Y) / 2 + r * DELTA_Y + DELTA_Y / 2;
    endfunction

    function automatic bit model_pix(int px, int py, output bit chg);
        bit on;
        int idx, ccx, ccy, ddx, ddy, g, c, rr, digit;
        string f;
        on  = 1'b0;
        chg = 1'b0;
        for (int r = 0; r < ROWS; r++) begin
            idx = m_first + r;
            ccx = int'(cx);
            ccy = row_centre_y(r);
            if (idx >= REG_COUNT || ccy < 0) continue;
            ddx = px - (ccx - 20);
            ddy = py - (ccy - 5);
            if (ddx < 0 || ddx >= 40 || ddy < 0 || ddy >= 10) continue;
            g  = ddx / 8;
            c  = (ddx % 8) / 2;
            rr = ddy / 2;
            if (c == 3) continue;
            digit = (g == 0) ? idx : int'((m_snap[idx] >> (4 * (4 - g))) & 16'hF);
            f = font_of(digit);
            if (f[rr * 4 + c] == 8'd35) begin
                on = 1'b1;
                if (model_hl(idx)) chg = 1'b1;
            end
        end
        return on;
    endfunction

    task automatic model_reset();
        m_first  = 0;
        m_pend   = 0;
        m_primed = 0;
        frame_no = 0;
        for (int i = 0; i < REG_COUNT; i++) begin
            m_snap[i]   = 16'h0;
            last_chg[i] = -1000;
        end
    endtask

    task automatic set_reg(int i, logic [15:0] v);
        live_m[i] = v;
        registers[(REG_COUNT - i) * 16 - 1 -: 16] = v;
    endtask

    task automatic do_reset(int n);
        rst = 1'b1;
        frame_start = 1'b0;
        page_next = 1'b0;
        repeat (n) @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
    endtask

    task automatic pulse_page();
        page_next = 1'b1;
        @(posedge clk);
        m_pend = 1'b1;
        #1 page_next = 1'b0;
    endtask

    task automatic pulse_frame(bit with_page);
        frame_start = 1'b1;
        page_next   = with_page;
        @(posedge clk);
        frame_no++;
        for (int i = 0; i < REG_COUNT; i++) begin
            if (m_primed && live_m[i] != m_snap[i]) last_chg[i] = frame_no;
            m_snap[i] = live_m[i];
        end
        m_primed = 1'b1;
        if (m_pend || with_page) m_first = (m_first + ROWS >= REG_COUNT) ? 0 : m_first + ROWS;
        m_pend = 1'b0;
        #1;
        frame_start = 1'b0;
        page_next   = 1'b0;
    endtask

    task automatic probe(int px, int py);
        x = 11'(px);
        y = 11'(py);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bit e, ec;
        cx = 11'd320; cy = 11'd300;
        for (int i = 0; i < REG_COUNT; i++) set_reg(i, 16'h0);
        do_reset(2);
        set_reg(0, 16'h1234);
        checks++; if (first_index !== 4'd0) begin errors++; $display("FAIL reset_first_index: got %0d want 0", first_index); end
        checks++; if (hit !== 1'b0) begin errors++; $display("FAIL reset_hit: got %b want 0", hit); end
        checks++; if (changed_hit !== 1'b0) begin errors++; $display("FAIL reset_changed_hit: got %b want 0", changed_hit); end
        probe(308, 205);
        checks++; if (hit !== 1'b1) begin errors++; $display("FAIL snap_old_zero: got %b want 1", hit); end
        pulse_frame(1'b0);
        probe(308, 205);
        checks++; if (hit !== 1'b0) begin errors++; $display("FAIL snap_new_1234_off: got %b want 0", hit); end
        probe(310, 205);
        checks++; if (hit !== 1'b1) begin errors++; $display("FAIL snap_new_1234_on: got %b want 1", hit); end
        for (int k = 0; k < 20; k++) begin
            probe(299 + int'($urandom_range(0, 41)), 204 + int'($urandom_range(0, 11)));
            e = model_pix(int'(x), int'(y), ec);
            checks++; if (hit !== e) begin errors++; $display("FAIL snap_row0 (%0d,%0d): got %b want %b", x, y, hit, e); end
        end
    endtask

    task automatic test_paging();
        int want [3] = '{4, 8, 0};
        int prev;
        cx = 11'd320; cy = 11'd300;
        do_reset(1);
        for (int p = 0; p < 3; p++) begin
            prev = m_first;
            repeat (3) pulse_page();
            checks++; if (first_index !== 4'(prev)) begin errors++; $display("FAIL page_hold p%0d: got %0d want %0d", p, first_index, prev); end
            pulse_frame(1'b0);
            checks++; if (first_index !== 4'(want[p])) begin errors++; $display("FAIL page_step p%0d: got %0d want %0d", p, first_index, want[p]); end
            if (p == 1) begin
                probe(300, 385);
                checks++; if (hit !== 1'b0) begin errors++; $display("FAIL page_blank_row3: got %b want 0", hit); end
                probe(302, 325);
                checks++; if (hit !== 1'b1) begin errors++; $display("FAIL page_row2_idxA: got %b want 1", hit); end
            end
        end
    endtask

    task automatic test_same_cycle();
        cx = 11'd320; cy = 11'd300;
        do_reset(1);
        pulse_frame(1'b1);
        checks++; if (first_index !== 4'd4) begin errors++; $display("FAIL same_cycle_adv: got %0d want 4", first_index); end
        pulse_frame(1'b0);
        checks++; if (first_index !== 4'd4) begin errors++; $display("FAIL same_cycle_pend_clear: got %0d want 4", first_index); end
    endtask

    task automatic test_latency();
        cx = 11'd320; cy = 11'd300;
        do_reset(1);
        probe(0, 0);
        checks++; if (hit !== 1'b0) begin errors++; $display("FAIL lat_off: got %b want 0", hit); end
        x = 11'd300; y = 11'd205;
        #2;
        checks++; if (hit !== 1'b0) begin errors++; $display("FAIL lat_early: got %b want 0", hit); end
        @(posedge clk); #1;
        checks++; if (hit !== 1'b1) begin errors++; $display("FAIL lat_rise: got %b want 1", hit); end
        probe(0, 0);
        checks++; if (hit !== 1'b0) begin errors++; $display("FAIL lat_fall: got %b want 0", hit); end
    endtask

    task automatic test_change_hilite();
        bit e, ec;
        int n_hl = 0;
        int want_hl;
        cx = 11'd320; cy = 11'd300;
        for (int i = 0; i < REG_COUNT; i++) set_reg(i, 16'h0);
        do_reset(1);
        set_reg(1, 16'd5);
        pulse_frame(1'b0);
        probe(302, 265);
        checks++; if (hit !== 1'b1) begin errors++; $display("FAIL hl_first_hit: got %b want 1", hit); end
        checks++; if (changed_hit !== 1'b0) begin errors++; $display("FAIL hl_first_frame: got %b want 0", changed_hit); end
        set_reg(1, 16'd6);
        for (int f = 0; f < 5; f++) begin
            pulse_frame(1'b0);
            probe(302, 265);
            e = model_pix(302, 265, ec);
            if (changed_hit === 1'b1) n_hl++;
            checks++; if (hit !== e) begin errors++; $display("FAIL hl_hit f%0d: got %b want %b", f, hit, e); end
            checks++; if (changed_hit !== ec) begin errors++; $display("FAIL hl_chg f%0d: got %b want %b", f, changed_hit, ec); end
            probe(300, 205);
            checks++; if (changed_hit !== 1'b0) begin errors++; $display("FAIL hl_row0 f%0d: got %b want 0", f, changed_hit); end
        end
`ifdef REG_HEAP_CHANGE_HILITE_EN
        want_hl = 3;
`else
        want_hl = 0;
`endif
        checks++; if (n_hl != want_hl) begin errors++; $display("FAIL hl_frames: got %0d want %0d", n_hl, want_hl); end
    endtask

    task automatic test_negative_centre();
        cx = 11'd320; cy = 11'd20;
        do_reset(1);
        pulse_frame(1'b0);
        probe(300, 1973);
        checks++; if (hit !== 1'b0) begin errors++; $display("FAIL neg_row0_wrap: got %b want 0", hit); end
        probe(300, 2033);
        checks++; if (hit !== 1'b0) begin errors++; $display("FAIL neg_row1_wrap: got %b want 0", hit); end
        probe(300, 45);
        checks++; if (hit !== 1'b1) begin errors++; $display("FAIL neg_row2_vis: got %b want 1", hit); end
    endtask

    task automatic test_reset_collisions();
        cx = 11'd320; cy = 11'd300;
        do_reset(1);
        set_reg(0, 16'hFFFF);
        rst = 1'b1; frame_start = 1'b1; page_next = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0; frame_start = 1'b0; page_next = 1'b0;
        model_reset();
        probe(310, 209);
        checks++; if (hit !== 1'b0) begin errors++; $display("FAIL rst_frame_nosnap: got %b want 0", hit); end
        pulse_frame(1'b0);
        checks++; if (first_index !== 4'd0) begin errors++; $display("FAIL rst_page_nolatch: got %0d want 0", first_index); end
        probe(310, 209);
        checks++; if (hit !== 1'b1) begin errors++; $display("FAIL rst_then_snap: got %b want 1", hit); end
    endtask

    task automatic test_random();
        bit e, ec;
        int r, ccy, px, py;
        cx = 11'($urandom_range(40, 1900));
        cy = 11'($urandom_range(20, 1900));
        do_reset(1);
        for (int it = 0; it < 40; it++) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                if ($urandom_range(0, 3) == 0) set_reg(i, 16'($urandom));
            end
            if ($urandom_range(0, 2) == 0) pulse_page();
            pulse_frame($urandom_range(0, 4) == 0);
            checks++; if (first_index !== 4'(m_first)) begin errors++; $display("FAIL rnd_first it%0d: got %0d want %0d", it, first_index, m_first); end
            for (int k = 0; k < 12; k++) begin
                r   = int'($urandom_range(0, ROWS - 1));
                ccy = row_centre_y(r);
                px  = int'(cx) - 21 + int'($urandom_range(0, 41));
                py  = ccy - 6 + int'($urandom_range(0, 11));
                if (px < 0) px = 0;
                if (py < 0) py = 0;
                if (py > 2047) py = 2047;
                probe(px, py);
                e = model_pix(px, py, ec);
                checks++; if (hit !== e) begin errors++; $display("FAIL rnd_hit it%0d (%0d,%0d): got %b want %b", it, px, py, hit, e); end
                checks++; if (changed_hit !== ec) begin errors++; $display("FAIL rnd_chg it%0d (%0d,%0d): got %b want %b", it, px, py, changed_hit, ec); end
            end
        end
    endtask

    initial begin
        rst = 1'b1; frame_start = 1'b0; page_next = 1'b0;
        x = '0; y = '0; cx = 11'd320; cy = 11'd300; registers = '0;
        for (int i = 0; i < REG_COUNT; i++) live_m[i] = 16'h0;
        model_reset();
        test_reset();
        test_paging();
        test_same_cycle();
        test_latency();
        test_change_hilite();
        test_negative_centre();
        test_reset_collisions();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
